// File: rtl/y_bus_receiver.sv
// Clocked, back-pressured receiver for the 8-bit y producer interface.
// Buffers y words in a small FIFO and presents the head word on o_b with a valid/ready handshake.
module y_bus_receiver #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_arst,
   input  logic                       en,
   input  logic                       i_y_valid,
   input  logic [W-1:0]               i_y_data,
   output logic                       o_y_ready,
   output logic [W-1:0]               o_b,
   output logic                       o_b_valid,
   input  logic                       i_b_ready,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } fill_e;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          ovf_q;
   logic          run_q;
   fill_e         fill_st;
   logic          push, pop;

   // Fill state is a pure function of the occupancy counter.
   always_comb begin
      fill_st = PARTIAL;
      if (count == '0)
         fill_st = EMPTY;
      else if (count == CW'(DEPTH))
         fill_st = FULL;
   end

   // run_q keeps ready low until the first clock edge after reset release.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst)
         run_q <= 1'b0;
      else
         run_q <= 1'b1;
   end

   assign o_b_valid = (fill_st != EMPTY);
   assign pop       = o_b_valid & i_b_ready;
   assign o_y_ready = run_q & en & ((fill_st != FULL) | pop);
   assign push      = i_y_valid & o_y_ready;

   // Head word comes straight from storage; no path from i_y_* to o_b.
   assign o_b        = o_b_valid ? mem[rd_ptr] : '0;
   assign o_count    = count;
   assign o_overflow = ovf_q;

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_y_data;
   end

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky: a word offered while full and not draining is lost.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst)
         ovf_q <= 1'b0;
      else if (i_y_valid & en & (fill_st == FULL) & ~pop)
         ovf_q <= 1'b1;
   end

endmodule
